std_store_drain_buffer: RTL

- FIFO of committed stores sitting directly upstream of the store request port of the non-blocking L1 dcache.
- Accepts committed stores from the store unit and drains them in order into the dcache controller port using the two-phase protocol: index/req, gnt, then tag with tag_valid one cycle later.
- Provides an index-match check so the load path can stall on a possible read-after-write to a buffered store.

---
 rtl/std_store_drain_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/std_store_drain_buffer.sv
// In-order buffer of committed stores draining into the L1 dcache request port (req/gnt, then tag).
// Optional macro STORE_DRAIN_MERGE_EN merges same-dword pushes into the youngest entry.

module std_store_drain_buffer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned TAG_WIDTH   = 44,
  parameter int unsigned DATA_WIDTH  = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_valid_i,
  output logic                      push_ready_o,
  input  logic [INDEX_WIDTH-1:0]    push_index_i,
  input  logic [TAG_WIDTH-1:0]      push_tag_i,
  input  logic [DATA_WIDTH-1:0]     push_data_i,
  input  logic [DATA_WIDTH/8-1:0]   push_be_i,
  input  logic [1:0]                push_size_i,
  input  logic                      stall_i,
  output logic                      req_o,
  input  logic                      gnt_i,
  output logic [INDEX_WIDTH-1:0]    index_o,
  output logic [TAG_WIDTH-1:0]      tag_o,
  output logic                      tag_valid_o,
  output logic                      we_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [DATA_WIDTH/8-1:0]   be_o,
  output logic [1:0]                size_o,
  input  logic [INDEX_WIDTH-1:0]    chk_index_i,
  output logic                      chk_hit_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = DATA_WIDTH / 8;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StTag  = 1'b1;

  logic [INDEX_WIDTH-1:0] index_q [DEPTH];
  logic [TAG_WIDTH-1:0]   tag_q   [DEPTH];
  logic [DATA_WIDTH-1:0]  data_q  [DEPTH];
  logic [BW-1:0]          be_q    [DEPTH];
  logic [1:0]             size_q  [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [0:0]    state_q, state_d;

  logic full;
  logic pop;
  logic merge;
  logic alloc;

  assign full         = (count_q == CW'(DEPTH));
  assign push_ready_o = ~full;
  assign req_o        = (state_q == StIdle) & (count_q != '0) & ~stall_i;
  assign tag_valid_o  = (state_q == StTag);
  assign pop          = (state_q == StTag);
  assign empty_o      = (count_q == '0) & (state_q == StIdle);
  assign count_o      = count_q;
  assign we_o         = 1'b1;

  assign index_o = index_q[rd_ptr_q];
  assign tag_o   = tag_q[rd_ptr_q];
  assign wdata_o = data_q[rd_ptr_q];
  assign be_o    = be_q[rd_ptr_q];
  assign size_o  = size_q[rd_ptr_q];

`ifdef STORE_DRAIN_MERGE_EN
  logic [PW-1:0] young_ptr;
  logic          merge_match;
  logic          merge_block;

  assign young_ptr   = wr_ptr_q - PW'(1);
  assign merge_match = (tag_q[young_ptr] == push_tag_i) &&
                       (index_q[young_ptr][INDEX_WIDTH-1:3] == push_index_i[INDEX_WIDTH-1:3]);
  // The youngest entry is also the head only when a single entry is buffered; it must stay
  // frozen once the dcache has seen its request.
  assign merge_block = (count_q == CW'(1)) & (tag_valid_o | req_o);
  assign merge       = push_valid_i & (count_q != '0) & merge_match & ~merge_block;
`else
  assign merge = 1'b0;
`endif

  assign alloc = push_valid_i & push_ready_o & ~merge;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle:  if (req_o && gnt_i) state_d = StTag;
      StTag:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    if (alloc) wr_ptr_d = wr_ptr_q + PW'(1);

    if (alloc && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!alloc && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      index_q[wr_ptr_q] <= push_index_i;
      tag_q[wr_ptr_q]   <= push_tag_i;
      data_q[wr_ptr_q]  <= push_data_i;
      be_q[wr_ptr_q]    <= push_be_i;
      size_q[wr_ptr_q]  <= push_size_i;
    end
`ifdef STORE_DRAIN_MERGE_EN
    if (merge) begin
      for (int b = 0; b < BW; b++) begin
        if (push_be_i[b]) data_q[young_ptr][8*b +: 8] <= push_data_i[8*b +: 8];
      end
      be_q[young_ptr]   <= be_q[young_ptr] | push_be_i;
      size_q[young_ptr] <= 2'd3;
    end
`endif
  end

  // Dword-granular RAW check over every occupied slot, including the in-flight head.
  always_comb begin
    logic [PW-1:0] off;
    chk_hit_o = 1'b0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) &&
          (index_q[i][INDEX_WIDTH-1:3] == chk_index_i[INDEX_WIDTH-1:3])) begin
        chk_hit_o = 1'b1;
      end
    end
  end

  logic unused_chk_low;
  assign unused_chk_low = ^chk_index_i[2:0];

endmodule
